multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle sequencer for the MIPS core. Replaces one-shot decode with an FSM that fetches, decodes, executes,
//  accesses memory and writes back over several cycles through a shared ALU and a single memory port.
//  Stalls on memory, halts on exit syscall, counts cycles and retired instructions.
// PARAMETERS
//  CNT_W  32  width of cycle_count / instr_count
// PORTS
//  clk          in   1      clock; all state updates on rising edge
//  rst          in   1      synchronous, active-high reset
//  op           in   6      IR[31:26], valid from DECODE onward
//  func         in   6      IR[5:0]
//  zero         in   1      ALU result == 0 (EX)
//  rs_neg       in   1      rs[31] (EX, BGEZ)
//  v0_is_10     in   1      $v0 == 10 (EX, SYSCALL)
//  mem_ready    in   1      memory port completes the access this cycle
//  resume       in   1      leave HALT
//  pc_write     out  1      load PC
//  pc_src       out  2      0 ALU result, 1 ALUOut (branch target), 2 jump target, 3 rs
//  ir_write     out  1      load IR
//  mem_read     out  1      memory read request (fetch or load)
//  mem_write    out  1      memory write request
//  iord         out  1      0 address = PC, 1 address = ALUOut
//  alu_src_a    out  1      0 PC, 1 rs
//  alu_src_b    out  2      0 rt, 1 const 4, 2 ext imm, 3 ext imm<<2
//  alu_op       out  4      0 SLL, 1 SRA, 2 SRL, 5 ADD, 6 SUB, 7 AND, 8 OR, 9 XOR, 10 NOR, 11 SLT, 12 SLTU
//  signed_ext   out  1      imm sign- (1) or zero-extend (0)
//  reg_write    out  1      register file write
//  reg_dst      out  2      0 rt, 1 rd, 2 $31
//  wb_src       out  2      0 ALUOut, 1 MDR, 2 MDR halfword zero-ext (LHU), 3 PC
//  disp_en      out  1      one-cycle pulse: non-exit SYSCALL
//  illegal      out  1      one-cycle pulse: undecoded op/func
//  halted       out  1      FSM in HALT
//  cycle_count  out  CNT_W  cycles since reset, frozen in HALT
//  instr_count  out  CNT_W  retired instructions
// BEHAVIOUR
//  States: FETCH, DECODE, EXEC, MEM, WB, HALT. Reset -> FETCH, counters 0. While rst high all enables/pulses are 0.
//  Outputs are a Moore decode of state + op/func. Unlisted outputs are 0.
//  FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=5. Stay until mem_ready.
//   On mem_ready: ir_write=1, pc_write=1, pc_src=0, then DECODE.
//  DECODE: alu_src_a=0, alu_src_b=3, signed_ext=1, alu_op=5 (branch target -> ALUOut). J: pc_write=1, pc_src=2, retire -> FETCH.
//   Undecoded op/func: illegal=1, retire -> FETCH. Otherwise -> EXEC.
//  EXEC by class:
//   R-ALU: alu_src_a=1, alu_src_b=0, alu_op per func -> WB (reg_dst=1, wb_src=0).
//   I-ALU (ADDI/ADDIU/SLTI sext; ANDI/ORI/XORI zext): alu_src_b=2 -> WB (reg_dst=0).
//   LW/LHU/SW: ADD rs+sext imm -> MEM.
//   BEQ/BNE: SUB rs,rt; pc_write = zero (BEQ) / !zero (BNE); pc_src=1; retire.
//   BGEZ: pc_write = !rs_neg, pc_src=1; retire.
//   JR: pc_write=1, pc_src=3; retire.
//   JAL: reg_write=1, reg_dst=2, wb_src=3 (PC already +4), pc_write=1, pc_src=2; retire.
//   SYSCALL: v0_is_10 -> HALT (retire counted); else disp_en=1, retire -> FETCH.
//  MEM: iord=1; SW mem_write=1 -> on mem_ready retire -> FETCH. Load: mem_read=1 -> on mem_ready WB.
//  WB: reg_write=1; load reg_dst=0, wb_src=1 (LW) / 2 (LHU); retire -> FETCH.
//  HALT: all enables 0, cycle_count frozen; resume=1 -> FETCH next cycle.
//  Counters: cycle_count +1 every non-HALT cycle; instr_count +1 on each retire. Both wrap modulo 2^CNT_W.
//  mem_ready held low: FSM waits indefinitely, request held stable. mem_ready outside FETCH/MEM is ignored.
//  rst during MEM/WB: the pending write is dropped, no retire, FETCH next cycle.
// STRUCTURE
//  Shared package mips_pkg: opcode/func localparams, ALU_* codes, state encoding, pc_src/wb_src/reg_dst encodings.
//  One sub-module mc_decode: combinational op/func -> {class, alu_op, signed_ext, illegal}.
//  Top holds the state register, the output decode and the counters.
// TESTING
//  ADDU $3,$1,$2 with mem_ready tied 1 -> FETCH,DECODE,EXEC,WB; reg_write only in WB (reg_dst=1); instr_count=1 after 4 cycles.
//  LW with mem_ready low 3 cycles in MEM -> mem_read,iord held 3 cycles; WB wb_src=1; total 8 cycles.
//  BEQ zero=1 -> pc_write=1,pc_src=1 in EXEC; zero=0 -> pc_write=0; both retire in 3 cycles.
//  JAL -> EXEC reg_write=1, reg_dst=2, wb_src=3, pc_src=2. Then SYSCALL v0_is_10=1 -> halted=1, cycle_count frozen; resume -> FETCH.
//  op=6'h3F -> illegal pulse 1 cycle in DECODE, instr_count+1, back to FETCH.
//  rst asserted in WB of LW -> no reg_write that cycle, FETCH next, counters 0; preload cycle_count near 2^CNT_W-1 -> wraps to 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer:
// opcodes, funcs, ALU codes, mux selects and FSM states.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] F_SLL     = 6'h00;
  localparam logic [5:0] F_SRL     = 6'h02;
  localparam logic [5:0] F_SRA     = 6'h03;
  localparam logic [5:0] F_JR      = 6'h08;
  localparam logic [5:0] F_SYSCALL = 6'h0C;
  localparam logic [5:0] F_ADD     = 6'h20;
  localparam logic [5:0] F_ADDU    = 6'h21;
  localparam logic [5:0] F_SUB     = 6'h22;
  localparam logic [5:0] F_SUBU    = 6'h23;
  localparam logic [5:0] F_AND     = 6'h24;
  localparam logic [5:0] F_OR      = 6'h25;
  localparam logic [5:0] F_XOR     = 6'h26;
  localparam logic [5:0] F_NOR     = 6'h27;
  localparam logic [5:0] F_SLT     = 6'h2A;
  localparam logic [5:0] F_SLTU    = 6'h2B;

  localparam logic [3:0] ALU_SLL  = 4'd0;
  localparam logic [3:0] ALU_SRA  = 4'd1;
  localparam logic [3:0] ALU_SRL  = 4'd2;
  localparam logic [3:0] ALU_ADD  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_AND  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_XOR  = 4'd9;
  localparam logic [3:0] ALU_NOR  = 4'd10;
  localparam logic [3:0] ALU_SLT  = 4'd11;
  localparam logic [3:0] ALU_SLTU = 4'd12;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;

  localparam logic [1:0] SRCB_RT   = 2'd0;
  localparam logic [1:0] SRCB_4    = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;
  localparam logic [1:0] SRCB_IMM2 = 2'd3;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MDR = 2'd1;
  localparam logic [1:0] WB_LHU = 2'd2;
  localparam logic [1:0] WB_PC  = 2'd3;

  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CL_ILL,
    CL_RALU,
    CL_IALU,
    CL_LW,
    CL_LHU,
    CL_SW,
    CL_BEQ,
    CL_BNE,
    CL_BGEZ,
    CL_JR,
    CL_J,
    CL_JAL,
    CL_SYSCALL
  } class_e;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: op/func to
// instruction class, ALU operation and extension mode.
module mc_decode
  import mips_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] func_i,
  output class_e     cls_o,
  output logic [3:0] alu_op_o,
  output logic       signed_ext_o,
  output logic       illegal_o
);

  always_comb begin
    cls_o        = CL_ILL;
    alu_op_o     = ALU_ADD;
    signed_ext_o = 1'b1;
    case (op_i)
      OP_RTYPE: begin
        case (func_i)
          F_SLL: begin
            cls_o    = CL_RALU;
            alu_op_o = ALU_SLL;
          end
          F_SRL: begin
            cls_o    = CL_RALU;
            alu_op_o = ALU_SRL;
          end
          F_SRA: begin
            cls_o    = CL_RALU;
            alu_op_o = ALU_SRA;
          end
          F_ADD, F_ADDU: begin
            cls_o    = CL_RALU;
            alu_op_o = ALU_ADD;
          end
          F_SUB, F_SUBU: begin
            cls_o    = CL_RALU;
            alu_op_o = ALU_SUB;
          end
          F_AND: begin
            cls_o    = CL_RALU;
            alu_op_o = ALU_AND;
          end
          F_OR: begin
            cls_o    = CL_RALU;
            alu_op_o = ALU_OR;
          end
          F_XOR: begin
            cls_o    = CL_RALU;
            alu_op_o = ALU_XOR;
          end
          F_NOR: begin
            cls_o    = CL_RALU;
            alu_op_o = ALU_NOR;
          end
          F_SLT: begin
            cls_o    = CL_RALU;
            alu_op_o = ALU_SLT;
          end
          F_SLTU: begin
            cls_o    = CL_RALU;
            alu_op_o = ALU_SLTU;
          end
          F_JR:      cls_o = CL_JR;
          F_SYSCALL: cls_o = CL_SYSCALL;
          default:   cls_o = CL_ILL;
        endcase
      end
      OP_REGIMM: cls_o = CL_BGEZ;
      OP_J:      cls_o = CL_J;
      OP_JAL:    cls_o = CL_JAL;
      OP_BEQ: begin
        cls_o    = CL_BEQ;
        alu_op_o = ALU_SUB;
      end
      OP_BNE: begin
        cls_o    = CL_BNE;
        alu_op_o = ALU_SUB;
      end
      OP_ADDI, OP_ADDIU: cls_o = CL_IALU;
      OP_SLTI: begin
        cls_o    = CL_IALU;
        alu_op_o = ALU_SLT;
      end
      OP_ANDI: begin
        cls_o        = CL_IALU;
        alu_op_o     = ALU_AND;
        signed_ext_o = 1'b0;
      end
      OP_ORI: begin
        cls_o        = CL_IALU;
        alu_op_o     = ALU_OR;
        signed_ext_o = 1'b0;
      end
      OP_XORI: begin
        cls_o        = CL_IALU;
        alu_op_o     = ALU_XOR;
        signed_ext_o = 1'b0;
      end
      OP_LW:   cls_o = CL_LW;
      OP_LHU:  cls_o = CL_LHU;
      OP_SW:   cls_o = CL_SW;
      default: cls_o = CL_ILL;
    endcase
    illegal_o = (cls_o == CL_ILL);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: state register, Moore
// output decode, cycle and retired-instruction counters.
module multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             rs_neg,
  input  logic             v0_is_10,
  input  logic             mem_ready,
  input  logic             resume,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_op,
  output logic             signed_ext,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wb_src,
  output logic             disp_en,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cyc_q, ins_q;
  logic             retire;

  class_e     cls;
  logic [3:0] dec_alu_op;
  logic       dec_sext;
  logic       dec_ill;

  mc_decode u_dec (
    .op_i         (op),
    .func_i       (func),
    .cls_o        (cls),
    .alu_op_o     (dec_alu_op),
    .signed_ext_o (dec_sext),
    .illegal_o    (dec_ill)
  );

  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_ALU;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_op     = ALU_SLL;
    signed_ext = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = RD_RT;
    wb_src     = WB_ALU;
    disp_en    = 1'b0;
    illegal    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_4;
        alu_op    = ALU_ADD;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b  = SRCB_IMM2;
        signed_ext = 1'b1;
        alu_op     = ALU_ADD;
        if (cls == CL_J) begin
          pc_write = 1'b1;
          pc_src   = PC_JUMP;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else if (dec_ill) begin
          illegal = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = dec_alu_op;
        state_d   = S_FETCH;
        case (cls)
          CL_RALU: state_d = S_WB;
          CL_IALU: begin
            alu_src_b  = SRCB_IMM;
            signed_ext = dec_sext;
            state_d    = S_WB;
          end
          CL_LW, CL_LHU, CL_SW: begin
            alu_src_b  = SRCB_IMM;
            signed_ext = 1'b1;
            alu_op     = ALU_ADD;
            state_d    = S_MEM;
          end
          CL_BEQ, CL_BNE: begin
            pc_write = (cls == CL_BEQ) ? zero : !zero;
            pc_src   = PC_ALUOUT;
            retire   = 1'b1;
          end
          CL_BGEZ: begin
            pc_write = !rs_neg;
            pc_src   = PC_ALUOUT;
            retire   = 1'b1;
          end
          CL_JR: begin
            pc_write = 1'b1;
            pc_src   = PC_RS;
            retire   = 1'b1;
          end
          CL_JAL: begin
            reg_write = 1'b1;
            reg_dst   = RD_RA;
            wb_src    = WB_PC;
            pc_write  = 1'b1;
            pc_src    = PC_JUMP;
            retire    = 1'b1;
          end
          CL_SYSCALL: begin
            retire = 1'b1;
            if (v0_is_10) state_d = S_HALT;
            else disp_en = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        iord = 1'b1;
        if (cls == CL_SW) begin
          mem_write = 1'b1;
          if (mem_ready) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end else begin
          mem_read = 1'b1;
          if (mem_ready) state_d = S_WB;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
        case (cls)
          CL_RALU: reg_dst = RD_RD;
          CL_LW:   wb_src  = WB_MDR;
          CL_LHU:  wb_src  = WB_LHU;
          default: ;
        endcase
      end
      S_HALT: begin
        if (resume) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // Reset overrides every side effect, including a pending write-back.
    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      disp_en   = 1'b0;
      illegal   = 1'b0;
      retire    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cyc_q   <= '0;
      ins_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q != S_HALT) cyc_q <= cyc_q + 1'b1;
      if (retire) ins_q <= ins_q + 1'b1;
    end
  end

  assign halted      = (state_q == S_HALT);
  assign cycle_count = cyc_q;
  assign instr_count = ins_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl, built with
// 8-bit counters so the wrap-around is reachable.
module tb_multicycle_ctrl;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic [5:0]       op;
  logic [5:0]       func;
  logic             zero;
  logic             rs_neg;
  logic             v0_is_10;
  logic             mem_ready;
  logic             resume;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             ir_write;
  logic             mem_read;
  logic             mem_write;
  logic             iord;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [3:0]       alu_op;
  logic             signed_ext;
  logic             reg_write;
  logic [1:0]       reg_dst;
  logic [1:0]       wb_src;
  logic             disp_en;
  logic             illegal;
  logic             halted;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instr_count;

  int nvec = 0;
  int nmis = 0;

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .op          (op),
    .func        (func),
    .zero        (zero),
    .rs_neg      (rs_neg),
    .v0_is_10    (v0_is_10),
    .mem_ready   (mem_ready),
    .resume      (resume),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .ir_write    (ir_write),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .iord        (iord),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .signed_ext  (signed_ext),
    .reg_write   (reg_write),
    .reg_dst     (reg_dst),
    .wb_src      (wb_src),
    .disp_en     (disp_en),
    .illegal     (illegal),
    .halted      (halted),
    .cycle_count (cycle_count),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ir(input logic [5:0] o, input logic [5:0] f);
    op   = o;
    func = f;
  endtask

  initial begin
    rst = 1'b1;
    set_ir(6'h00, 6'h00);
    zero = 0; rs_neg = 0; v0_is_10 = 0;
    mem_ready = 1; resume = 0;
    tick();
    tick();
    chk("rst_mem_read", mem_read, 0);
    chk("rst_pc_write", pc_write, 0);
    chk("rst_ir_write", ir_write, 0);
    rst = 1'b0;
    #1;
    chk("rst_cyc", cycle_count, 0);
    chk("rst_ins", instr_count, 0);
    chk("rst_halted", halted, 0);

    // ADDU $3,$1,$2
    set_ir(6'h00, 6'h21);
    #1;
    chk("addu_f_mrd", mem_read, 1);
    chk("addu_f_irw", ir_write, 1);
    chk("addu_f_pcw", pc_write, 1);
    chk("addu_f_srcb", alu_src_b, 1);
    chk("addu_f_aop", alu_op, 5);
    chk("addu_f_rw", reg_write, 0);
    tick();
    chk("addu_d_srcb", alu_src_b, 3);
    chk("addu_d_sext", signed_ext, 1);
    chk("addu_d_rw", reg_write, 0);
    tick();
    chk("addu_e_srca", alu_src_a, 1);
    chk("addu_e_srcb", alu_src_b, 0);
    chk("addu_e_aop", alu_op, 5);
    chk("addu_e_rw", reg_write, 0);
    tick();
    chk("addu_w_rw", reg_write, 1);
    chk("addu_w_dst", reg_dst, 1);
    chk("addu_w_wb", wb_src, 0);
    tick();
    chk("addu_ins", instr_count, 1);
    chk("addu_cyc", cycle_count, 4);

    // LW with three stalled memory cycles
    set_ir(6'h23, 6'h00);
    tick();
    tick();
    chk("lw_e_srcb", alu_src_b, 2);
    chk("lw_e_aop", alu_op, 5);
    mem_ready = 0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("lw_m_mrd", mem_read, 1);
      chk("lw_m_iord", iord, 1);
      chk("lw_m_rw", reg_write, 0);
      tick();
    end
    mem_ready = 1;
    #1;
    chk("lw_m_rdy_mrd", mem_read, 1);
    tick();
    chk("lw_w_rw", reg_write, 1);
    chk("lw_w_wb", wb_src, 1);
    chk("lw_w_dst", reg_dst, 0);
    tick();
    chk("lw_ins", instr_count, 2);
    chk("lw_cyc", cycle_count, 12);

    // BEQ taken then not taken
    set_ir(6'h04, 6'h00);
    zero = 1;
    tick();
    tick();
    chk("beq1_pcw", pc_write, 1);
    chk("beq1_src", pc_src, 1);
    chk("beq1_aop", alu_op, 6);
    tick();
    chk("beq1_ins", instr_count, 3);
    chk("beq1_cyc", cycle_count, 15);
    zero = 0;
    tick();
    tick();
    chk("beq0_pcw", pc_write, 0);
    tick();
    chk("beq0_ins", instr_count, 4);
    chk("beq0_cyc", cycle_count, 18);

    // JAL
    set_ir(6'h03, 6'h00);
    tick();
    chk("jal_d_pcw", pc_write, 0);
    tick();
    chk("jal_e_rw", reg_write, 1);
    chk("jal_e_dst", reg_dst, 2);
    chk("jal_e_wb", wb_src, 3);
    chk("jal_e_pcw", pc_write, 1);
    chk("jal_e_src", pc_src, 2);
    tick();
    chk("jal_ins", instr_count, 5);

    // SYSCALL exit, halt, resume
    set_ir(6'h00, 6'h0C);
    v0_is_10 = 1;
    tick();
    tick();
    chk("sys_e_disp", disp_en, 0);
    tick();
    chk("halt_flag", halted, 1);
    chk("halt_ins", instr_count, 6);
    chk("halt_cyc", cycle_count, 24);
    tick();
    tick();
    tick();
    chk("halt_cyc_frz", cycle_count, 24);
    chk("halt_mrd", mem_read, 0);
    resume = 1;
    tick();
    resume = 0;
    v0_is_10 = 0;
    #1;
    chk("resume_halted", halted, 0);
    chk("resume_mrd", mem_read, 1);
    chk("resume_cyc", cycle_count, 24);

    // SYSCALL without exit
    tick();
    tick();
    chk("sys_disp", disp_en, 1);
    tick();
    chk("sys_disp_off", disp_en, 0);
    chk("sys_ins", instr_count, 7);
    chk("sys_halted", halted, 0);

    // J retires from DECODE
    set_ir(6'h02, 6'h00);
    tick();
    chk("j_pcw", pc_write, 1);
    chk("j_src", pc_src, 2);
    tick();
    chk("j_ins", instr_count, 8);
    chk("j_fetch", mem_read, 1);

    // Undecoded opcode
    set_ir(6'h3F, 6'h00);
    tick();
    chk("ill_pulse", illegal, 1);
    tick();
    chk("ill_off", illegal, 0);
    chk("ill_ins", instr_count, 9);
    chk("ill_cyc", cycle_count, 31);

    // SW waits for mem_ready then retires
    set_ir(6'h2B, 6'h00);
    tick();
    tick();
    mem_ready = 0;
    tick();
    chk("sw_m_mwr", mem_write, 1);
    chk("sw_m_mrd", mem_read, 0);
    tick();
    chk("sw_m_hold", mem_write, 1);
    chk("sw_m_ins", instr_count, 9);
    mem_ready = 1;
    tick();
    chk("sw_ins", instr_count, 10);

    // Reset in WB of LW drops the write
    set_ir(6'h23, 6'h00);
    tick();
    tick();
    tick();
    tick();
    chk("lwr_w_rw_pre", reg_write, 1);
    rst = 1;
    #1;
    chk("lwr_w_rw", reg_write, 0);
    tick();
    rst = 0;
    #1;
    chk("lwr_fetch", mem_read, 1);
    chk("lwr_cyc", cycle_count, 0);
    chk("lwr_ins", instr_count, 0);

    // Cycle counter wrap while stalled in FETCH
    mem_ready = 0;
    for (int i = 0; i < 255; i++) tick();
    chk("wrap_ff", cycle_count, 255);
    chk("wrap_irw", ir_write, 0);
    chk("wrap_mrd", mem_read, 1);
    tick();
    chk("wrap_0", cycle_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
